uart_dump_ctrl: RTL and testbench

Sequencer for the monitor's memory-dump commands (r = data memory, p = instruction memory).
- Latches start/end byte addresses from the command decoder.
- Walks the word range, issues one read per word to the selected memory, and converts each word to ASCII hex.
- Feeds the characters one at a time to the UART transmitter.
- Drives dump_running back to the command decoder, so that block's dump state holds until the walk completes or is aborted.

---
 rtl/uart_dump_ctrl.sv | 177 +++++++++++++++++
 tb/tb_uart_dump_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_dump_ctrl.sv
// Memory-dump sequencer for the monitor's r/p commands: walks a word range,
// reads each word and streams it to the UART as lowercase hex, WPL words per line.
module uart_dump_ctrl #(
  parameter int AW  = 12,
  parameter int WPL = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   uart_data,
  input  logic          read_start_set,
  input  logic          read_end_set,
  input  logic          read_stop,
  input  logic          pgm_start_set,
  input  logic          pgm_end_set,
  input  logic          pgm_stop,
  input  logic          quit_cmd,
  output logic          dump_running,
  output logic          rd_req,
  output logic          rd_sel,
  output logic [AW-1:0] rd_adr,
  input  logic          rd_valid,
  input  logic [31:0]   rd_data,
  output logic          tx_req,
  output logic [7:0]    tx_char,
  input  logic          tx_ack
);

  localparam int WCW = $clog2(WPL + 1);
  localparam logic [WCW-1:0] WPL_LAST = WCW'(WPL - 1);
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0d;
  localparam logic [7:0] CH_LF = 8'h0a;

  typedef enum logic [2:0] {IDLE, RDREQ, HEX, SEP, LINE, EOL} state_t;

  state_t         state_q;
  logic [AW-1:0]  start_q, end_q, cur_q;
  logic           sel_q;
  logic [WCW-1:0] wcnt_q;
  logic [2:0]     nib_q;
  logic [31:0]    data_q;
  logic           lf_q;

  logic [AW-1:0]  adr_d;
  logic [AW-1:0]  cur_d;
  logic [2:0]     nib_d;
  logic [3:0]     next_nib;
  logic           abort;
  logic           unused_ok;

  assign adr_d    = uart_data[AW+1:2];
  assign cur_d    = cur_q + AW'(1);
  assign nib_d    = nib_q - 3'd1;
  assign next_nib = data_q[{nib_d, 2'b00} +: 4];
  assign abort    = quit_cmd | (read_stop & ~sel_q) | (pgm_stop & sel_q);
  assign rd_sel   = sel_q;
  assign unused_ok = ^{uart_data[31:AW+2], uart_data[1:0]};

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // Abort wins over any handshake arriving in the same cycle; nothing is flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      start_q      <= '0;
      end_q        <= '0;
      cur_q        <= '0;
      sel_q        <= 1'b0;
      wcnt_q       <= '0;
      nib_q        <= '0;
      data_q       <= '0;
      lf_q         <= 1'b0;
      dump_running <= 1'b0;
      rd_req       <= 1'b0;
      rd_adr       <= '0;
      tx_req       <= 1'b0;
      tx_char      <= '0;
    end else if (state_q != IDLE && abort) begin
      state_q      <= IDLE;
      dump_running <= 1'b0;
      rd_req       <= 1'b0;
      tx_req       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (read_start_set || pgm_start_set) begin
            start_q <= adr_d;
            sel_q   <= pgm_start_set & ~read_start_set;
          end
          if (read_end_set || pgm_end_set) begin
            end_q        <= adr_d;
            cur_q        <= start_q;
            wcnt_q       <= '0;
            lf_q         <= 1'b0;
            dump_running <= 1'b1;
            if (adr_d < start_q) begin
              state_q <= EOL;
              tx_req  <= 1'b1;
              tx_char <= CH_CR;
            end else begin
              state_q <= RDREQ;
              rd_req  <= 1'b1;
              rd_adr  <= start_q;
            end
          end
        end
        RDREQ: begin
          if (rd_valid) begin
            data_q  <= rd_data;
            nib_q   <= 3'd7;
            rd_req  <= 1'b0;
            tx_req  <= 1'b1;
            tx_char <= hex_char(rd_data[31:28]);
            state_q <= HEX;
          end
        end
        HEX: begin
          if (tx_ack) begin
            if (nib_q != 3'd0) begin
              nib_q   <= nib_d;
              tx_char <= hex_char(next_nib);
            end else begin
              tx_char <= CH_SP;
              state_q <= SEP;
            end
          end
        end
        SEP: begin
          if (tx_ack) begin
            if (cur_q == end_q) begin
              tx_char <= CH_CR;
              lf_q    <= 1'b0;
              state_q <= EOL;
            end else begin
              cur_q <= cur_d;
              if (wcnt_q == WPL_LAST) begin
                wcnt_q  <= '0;
                tx_char <= CH_CR;
                lf_q    <= 1'b0;
                state_q <= LINE;
              end else begin
                wcnt_q  <= wcnt_q + WCW'(1);
                tx_req  <= 1'b0;
                rd_req  <= 1'b1;
                rd_adr  <= cur_d;
                state_q <= RDREQ;
              end
            end
          end
        end
        LINE, EOL: begin
          if (tx_ack) begin
            if (!lf_q) begin
              lf_q    <= 1'b1;
              tx_char <= CH_LF;
            end else begin
              lf_q   <= 1'b0;
              tx_req <= 1'b0;
              if (state_q == LINE) begin
                rd_req  <= 1'b1;
                rd_adr  <= cur_q;
                state_q <= RDREQ;
              end else begin
                dump_running <= 1'b0;
                state_q      <= IDLE;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_dump_ctrl.sv
// Directed bench for uart_dump_ctrl: memory and UART responders answer after two
// cycles, transmitted characters are collected and compared against expected text.
module tb_uart_dump_ctrl;

  localparam logic [6:0] READ_START = 7'b0000001;
  localparam logic [6:0] READ_END   = 7'b0000010;
  localparam logic [6:0] READ_STOP  = 7'b0000100;
  localparam logic [6:0] PGM_START  = 7'b0001000;
  localparam logic [6:0] PGM_END    = 7'b0010000;
  localparam logic [6:0] PGM_STOP   = 7'b0100000;
  localparam logic [6:0] QUIT       = 7'b1000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] uart_data;
  logic        read_start_set, read_end_set, read_stop;
  logic        pgm_start_set, pgm_end_set, pgm_stop, quit_cmd;
  logic        dump_running, rd_req, rd_sel;
  logic [11:0] rd_adr;
  logic        rd_valid = 1'b0;
  logic [31:0] rd_data = '0;
  logic        tx_req;
  logic [7:0]  tx_char;
  logic        tx_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  bit memAuto = 1'b1, txAuto = 1'b1, manualAck = 1'b0, manualValid = 1'b0;
  int txLimit = 1000000;
  int memWait = 0, txWait = 0;
  int readCount = 0, highTotal = 0;
  int readBase, highBase, gotBase;
  logic [11:0] lastAdr = '0;
  logic        lastSel = 1'b0;
  logic [7:0]  gotQ[$];
  logic [7:0]  expQ[$];

  uart_dump_ctrl #(.AW(12), .WPL(4)) dut (
    .clk(clk), .rst_n(rst_n), .uart_data(uart_data),
    .read_start_set(read_start_set), .read_end_set(read_end_set), .read_stop(read_stop),
    .pgm_start_set(pgm_start_set), .pgm_end_set(pgm_end_set), .pgm_stop(pgm_stop),
    .quit_cmd(quit_cmd), .dump_running(dump_running),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_adr(rd_adr), .rd_valid(rd_valid), .rd_data(rd_data),
    .tx_req(tx_req), .tx_char(tx_char), .tx_ack(tx_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input int adr);
    if (adr == 4) return 32'hdeadbeef;
    return 32'h1f2e3d4c ^ (adr * 32'h01030507);
  endfunction

  // Memory answers two cycles after a request is seen; manual mode drives stray pulses.
  always @(negedge clk) begin
    if (memAuto) begin
      rd_valid = 1'b0;
      if (rd_req) begin
        memWait++;
        if (memWait == 2) begin
          rd_valid = 1'b1;
          rd_data  = memWord(int'(rd_adr));
          lastAdr  = rd_adr;
          lastSel  = rd_sel;
          readCount++;
          memWait  = 0;
        end
      end else memWait = 0;
    end else rd_valid = manualValid;
  end

  // Transmitter accepts each character after two cycles, stalling once txLimit is reached.
  always @(negedge clk) begin
    if (txAuto) begin
      tx_ack = 1'b0;
      if (tx_req && gotQ.size() < txLimit) begin
        txWait++;
        if (txWait == 2) begin
          tx_ack = 1'b1;
          gotQ.push_back(tx_char);
          txWait = 0;
        end
      end else txWait = 0;
    end else tx_ack = manualAck;
  end

  always @(negedge clk) if (dump_running) highTotal++;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] p, input logic [31:0] d);
    uart_data = d;
    {quit_cmd, pgm_stop, pgm_end_set, pgm_start_set, read_stop, read_end_set, read_start_set} = p;
    @(negedge clk);
    {quit_cmd, pgm_stop, pgm_end_set, pgm_start_set, read_stop, read_end_set, read_start_set} = '0;
  endtask

  task automatic captureBases();
    readBase = readCount;
    highBase = highTotal;
    gotBase  = gotQ.size();
  endtask

  task automatic startDump(input bit pgm, input logic [31:0] s, input logic [31:0] e);
    applyStimulus(pgm ? PGM_START : READ_START, s);
    captureBases();
    applyStimulus(pgm ? PGM_END : READ_END, e);
    checkOutput("running after end_set", dump_running, 1'b1);
  endtask

  task automatic waitIdle(input int maxCycles);
    int n = 0;
    while (dump_running && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxCycles) checkOutput("idle timeout", 1'b1, 1'b0);
  endtask

  task automatic waitChars(input int target, input int maxCycles);
    int n = 0;
    while (gotQ.size() < target && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxCycles) checkOutput("char timeout", 1'b1, 1'b0);
    @(negedge clk);
  endtask

  task automatic setExpLiteral(input string s);
    expQ.delete();
    for (int i = 0; i < s.len(); i++) expQ.push_back(s[i]);
    expQ.push_back(8'h20);
    expQ.push_back(8'h0d);
    expQ.push_back(8'h0a);
  endtask

  task automatic buildExp(input int s, input int e);
    string str;
    int n = 0;
    expQ.delete();
    for (int w = s; w <= e; w++) begin
      str = $sformatf("%08h", memWord(w));
      for (int k = 0; k < 8; k++) expQ.push_back(str[k]);
      expQ.push_back(8'h20);
      n++;
      if (w != e && n == 4) begin
        n = 0;
        expQ.push_back(8'h0d);
        expQ.push_back(8'h0a);
      end
    end
    expQ.push_back(8'h0d);
    expQ.push_back(8'h0a);
  endtask

  task automatic checkSeq(input string tag);
    int got = gotQ.size() - gotBase;
    checkOutput($sformatf("%s length", tag), got, expQ.size());
    for (int i = 0; i < expQ.size() && i < got; i++)
      checkOutput($sformatf("%s char %0d", tag, i), gotQ[gotBase + i], expQ[i]);
  endtask

  initial begin
    string s5;
    rst_n = 1'b0;
    uart_data = '0;
    {quit_cmd, pgm_stop, pgm_end_set, pgm_start_set, read_stop, read_end_set, read_start_set} = '0;
    @(negedge clk);
    checkOutput("reset dump_running", dump_running, 1'b0);
    checkOutput("reset rd_req", rd_req, 1'b0);
    checkOutput("reset tx_req", tx_req, 1'b0);
    checkOutput("reset tx_char", tx_char, 8'h00);
    checkOutput("reset rd_adr", rd_adr, 12'h000);
    rst_n = 1'b1;
    @(negedge clk);

    // One data word
    startDump(1'b0, 32'h10, 32'h10);
    checkOutput("t1 rd_req", rd_req, 1'b1);
    checkOutput("t1 rd_adr", rd_adr, 12'h004);
    checkOutput("t1 rd_sel", rd_sel, 1'b0);
    waitIdle(500);
    setExpLiteral("deadbeef");
    checkSeq("t1");
    checkOutput("t1 reads", readCount - readBase, 1);
    checkOutput("t1 running cycles", highTotal - highBase, 24);

    // Line wrap on an instruction dump
    startDump(1'b1, 32'h0, 32'h14);
    checkOutput("t2 rd_sel", rd_sel, 1'b1);
    waitIdle(2000);
    buildExp(0, 5);
    checkSeq("t2");
    checkOutput("t2 total chars", gotQ.size() - gotBase, 58);
    checkOutput("t2 wrap CR", gotQ[gotBase + 36], 8'h0d);
    checkOutput("t2 reads", readCount - readBase, 6);
    checkOutput("t2 last sel", lastSel, 1'b1);

    // Reversed range sends only CR LF
    startDump(1'b0, 32'h20, 32'h10);
    checkOutput("t3 rd_req", rd_req, 1'b0);
    checkOutput("t3 tx_req", tx_req, 1'b1);
    checkOutput("t3 first char", tx_char, 8'h0d);
    waitIdle(500);
    expQ.delete();
    expQ.push_back(8'h0d);
    expQ.push_back(8'h0a);
    checkSeq("t3");
    checkOutput("t3 reads", readCount - readBase, 0);
    checkOutput("t3 running cycles", highTotal - highBase, 4);

    // Abort on the 3rd hex char of the second word, then strays are ignored
    txLimit = gotQ.size() + 11;
    startDump(1'b0, 32'h10, 32'h1c);
    waitChars(txLimit, 500);
    s5 = $sformatf("%08h", memWord(5));
    checkOutput("t4 stalled tx_req", tx_req, 1'b1);
    checkOutput("t4 stalled char", tx_char, s5[2]);
    applyStimulus(QUIT, 32'h0);
    checkOutput("t4 abort tx_req", tx_req, 1'b0);
    checkOutput("t4 abort rd_req", rd_req, 1'b0);
    checkOutput("t4 abort running", dump_running, 1'b0);
    txAuto = 1'b0;
    memAuto = 1'b0;
    manualAck = 1'b1;
    manualValid = 1'b1;
    @(negedge clk);
    manualAck = 1'b0;
    manualValid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("t4 stray tx_req", tx_req, 1'b0);
    checkOutput("t4 stray rd_req", rd_req, 1'b0);
    checkOutput("t4 stray running", dump_running, 1'b0);
    txAuto = 1'b1;
    memAuto = 1'b1;
    txLimit = 1000000;
    @(negedge clk);
    startDump(1'b0, 32'h10, 32'h20);
    waitIdle(2000);
    buildExp(4, 8);
    checkSeq("t4 restart");
    checkOutput("t4 restart wrap CR", gotQ[gotBase + 36], 8'h0d);

    // read_stop must not touch a p dump; pgm_stop does
    txLimit = gotQ.size() + 3;
    startDump(1'b1, 32'h0, 32'hc);
    waitChars(txLimit, 500);
    applyStimulus(READ_STOP, 32'h0);
    checkOutput("t5 read_stop running", dump_running, 1'b1);
    checkOutput("t5 read_stop tx_req", tx_req, 1'b1);
    applyStimulus(PGM_STOP, 32'h0);
    checkOutput("t5 pgm_stop running", dump_running, 1'b0);
    checkOutput("t5 pgm_stop tx_req", tx_req, 1'b0);
    txLimit = 1000000;
    @(negedge clk);

    // Top of memory
    startDump(1'b0, 32'h3ffc, 32'h3ffc);
    checkOutput("t6 rd_adr", rd_adr, 12'hfff);
    waitIdle(500);
    buildExp(4095, 4095);
    checkSeq("t6");
    checkOutput("t6 reads", readCount - readBase, 1);
    checkOutput("t6 last adr", lastAdr, 12'hfff);
    checkOutput("t6 idle", dump_running, 1'b0);

    // Asynchronous reset while waiting in RDREQ
    memAuto = 1'b0;
    startDump(1'b0, 32'h10, 32'h10);
    repeat (2) @(negedge clk);
    checkOutput("t7 waiting rd_req", rd_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t7 async rd_req", rd_req, 1'b0);
    checkOutput("t7 async running", dump_running, 1'b0);
    checkOutput("t7 async rd_adr", rd_adr, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    memAuto = 1'b1;
    @(negedge clk);
    checkOutput("t7 idle running", dump_running, 1'b0);
    captureBases();
    applyStimulus(READ_END, 32'h0);
    checkOutput("t7 start cleared", rd_adr, 12'h000);
    checkOutput("t7 rd_req", rd_req, 1'b1);
    waitIdle(500);
    buildExp(0, 0);
    checkSeq("t7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
